// File: rtl/perst_pkg.sv
// Shared state encoding for the slot PERST# receiver.
// State values are visible to the BMC through oState.
package perst_pkg;

  localparam int ST_W = 2;

  typedef logic [ST_W-1:0] st_t;

  localparam st_t ST_RESET    = 2'd0;
  localparam st_t ST_CORE_DLY = 2'd1;
  localparam st_t ST_IO_DLY   = 2'd2;
  localparam st_t ST_RUN      = 2'd3;

endpackage

// File: rtl/perst_rx_filter.sv
// Two-flop synchronizer plus saturating deassertion filter.
// A short high pulse that dies before qualification is flagged.
module perst_rx_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic qual,
  output logic glitch
);

  localparam int FW = 8;
  localparam logic [FW-1:0] FMAX = FW'(FILT_CYC);

  logic          s1;
  logic          s2;
  logic [FW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (!s2) begin
        cnt <= '0;
      end else if (cnt != FMAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign sync   = s2;
  assign qual   = (cnt == FMAX);
  // cnt still holds the run length on the cycle sync falls
  assign glitch = !s2 && (cnt != '0) && (cnt < FMAX);

endmodule

// File: rtl/perst_rx.sv
// Slot PERST# receiver: qualifies PERST#/power-good, enforces
// minimum assertion, and releases core then IO reset in sequence.
module perst_rx
  import perst_pkg::*;
#(
  parameter int FILT_CYC       = 4,
  parameter int MIN_ASSERT_CYC = 200000,
  parameter int CORE_DLY_CYC   = 200,
  parameter int IO_DLY_CYC     = 2000,
  parameter int CNT_W          = 20
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             RST_PCIE_DEV_PERST_N,
  input  logic             PWRGD_LOCAL,
  input  logic             iClrErr,
  output logic             oRST_CORE_N,
  output logic             oRST_IO_N,
  output logic [ST_W-1:0]  oState,
  output logic             oGlitch,
  output logic             oEarlyErr
);

  localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_ASSERT_CYC);
  // delay states last exactly N cycles, counter ends at 0
  localparam logic [CNT_W-1:0] CORE_LD = CNT_W'(CORE_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] IO_LD   = CNT_W'(IO_DLY_CYC - 1);

  logic             s_perst;
  logic             q_perst;
  logic             q_perst_d;
  logic             glitch_evt;
  logic             pg1;
  logic             s_pg;
  st_t              state;
  st_t              state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_dec;
  logic             expired;
  logic             assert_rst;
  logic             early_evt;
  logic             core_nxt;
  logic             io_nxt;

  perst_rx_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_filt (
    .clk    (iClk),
    .rst    (iRst),
    .din    (RST_PCIE_DEV_PERST_N),
    .sync   (s_perst),
    .qual   (q_perst),
    .glitch (glitch_evt)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      pg1       <= 1'b0;
      s_pg      <= 1'b0;
      q_perst_d <= 1'b0;
    end else begin
      pg1       <= PWRGD_LOCAL;
      s_pg      <= pg1;
      q_perst_d <= q_perst;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= ST_RESET;
      cnt   <= MIN_LD;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign expired    = (cnt == '0);
  assign cnt_dec    = expired ? '0 : cnt - 1'b1;
  assign assert_rst = !s_perst || !s_pg;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (assert_rst) begin
      state_nxt = ST_RESET;
      cnt_nxt   = (state == ST_RESET) ? cnt_dec : MIN_LD;
    end else begin
      unique case (state)
        ST_RESET: begin
          if (q_perst && expired) begin
            state_nxt = ST_CORE_DLY;
            cnt_nxt   = CORE_LD;
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
        ST_CORE_DLY: begin
          if (expired) begin
            state_nxt = ST_IO_DLY;
            cnt_nxt   = IO_LD;
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
        ST_IO_DLY: begin
          if (expired) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt_dec;
          end
        end
        ST_RUN: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    core_nxt = (state_nxt == ST_IO_DLY) || (state_nxt == ST_RUN);
    io_nxt   = (state_nxt == ST_RUN);
  end

  // host released early while min-assert still running
  assign early_evt = (state == ST_RESET) && q_perst
                  && !q_perst_d && !expired;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oRST_CORE_N <= 1'b0;
      oRST_IO_N   <= 1'b0;
      oGlitch     <= 1'b0;
      oEarlyErr   <= 1'b0;
    end else begin
      oRST_CORE_N <= core_nxt;
      oRST_IO_N   <= io_nxt;
      oGlitch     <= glitch_evt || (oGlitch && !iClrErr);
      oEarlyErr   <= early_evt || (oEarlyErr && !iClrErr);
    end
  end

  assign oState = state;

endmodule

// File: tb/tb_perst_rx.sv
// Directed + random bench for perst_rx against a timestamp model.
// Model works from input history and entry/exit edge times.
module tb_perst_rx;

  localparam int F    = 4;
  localparam int MIN  = 16;
  localparam int CORE = 8;
  localparam int IO   = 4;
  localparam int MAXN = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       perst = 1'b0;
  logic       pg = 1'b1;
  logic       clr = 1'b0;
  logic       core_n;
  logic       io_n;
  logic [1:0] st;
  logic       glitch;
  logic       early;

  int checks = 0;
  int errors = 0;

  bit p_h [MAXN];
  bit g_h [MAXN];
  bit r_h [MAXN];
  bit c_h [MAXN];
  int n = 0;

  int m_st = 0;
  int t_ent = 0;
  int t_x = 0;
  bit m_gl = 0;
  bit m_er = 0;

  perst_rx #(
    .FILT_CYC       (F),
    .MIN_ASSERT_CYC (MIN),
    .CORE_DLY_CYC   (CORE),
    .IO_DLY_CYC     (IO),
    .CNT_W          (20)
  ) dut (
    .iClk                 (clk),
    .iRst                 (rst),
    .RST_PCIE_DEV_PERST_N (perst),
    .PWRGD_LOCAL          (pg),
    .iClrErr              (clr),
    .oRST_CORE_N          (core_n),
    .oRST_IO_N            (io_n),
    .oState               (st),
    .oGlitch              (glitch),
    .oEarlyErr            (early)
  );

  always #5 clk = ~clk;

  function automatic bit sp_at(input int m);
    if (m < 1) return 1'b0;
    if (r_h[m] || r_h[m-1]) return 1'b0;
    return p_h[m-1];
  endfunction

  function automatic bit sg_at(input int m);
    if (m < 1) return 1'b0;
    if (r_h[m] || r_h[m-1]) return 1'b0;
    return g_h[m-1];
  endfunction

  // qualified after edge m: last F synced samples all high
  function automatic bit qual_at(input int m);
    if (m < 0) return 1'b0;
    if (r_h[m]) return 1'b0;
    for (int k = 1; k <= F; k++)
      if (!sp_at(m - k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit glitch_ev(input int e);
    int len;
    if (e < 1) return 1'b0;
    if (r_h[e-1] || sp_at(e - 1)) return 1'b0;
    len = 0;
    for (int k = 2; k <= F + 1; k++) begin
      if (!sp_at(e - k)) break;
      len++;
    end
    return (len >= 1) && (len < F);
  endfunction

  task automatic model_edge(input int e);
    bit sp1, sg1, q1, q2, gev, eev;
    sp1 = sp_at(e - 1);
    sg1 = sg_at(e - 1);
    q1  = qual_at(e - 1);
    q2  = qual_at(e - 2);
    if (r_h[e]) begin
      m_st  = 0;
      t_ent = e;
      m_gl  = 1'b0;
      m_er  = 1'b0;
    end else begin
      gev  = glitch_ev(e);
      eev  = (m_st == 0) && q1 && !q2 && (e - t_ent <= MIN);
      m_gl = gev || (m_gl && !c_h[e]);
      m_er = eev || (m_er && !c_h[e]);
      if (!sp1 || !sg1) begin
        if (m_st != 0) t_ent = e;
        m_st = 0;
      end else begin
        case (m_st)
          0: if (q1 && (e - t_ent > MIN)) begin
               m_st = 1;
               t_x  = e;
             end
          1: if (e - t_x == CORE) begin
               m_st = 2;
               t_x  = e;
             end
          2: if (e - t_x == IO) m_st = 3;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] got,
                     input logic [1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d",
             tag, got, exp, n);
    end
  endtask

  task automatic step();
    p_h[n] = perst;
    g_h[n] = pg;
    r_h[n] = rst;
    c_h[n] = clr;
    @(posedge clk);
    model_edge(n);
    n++;
    #1;
    chk("m_core", {1'b0, core_n}, {1'b0, m_st >= 2});
    chk("m_io", {1'b0, io_n}, {1'b0, m_st == 3});
    chk("m_state", st, 2'(m_st));
    chk("m_glitch", {1'b0, glitch}, {1'b0, m_gl});
    chk("m_early", {1'b0, early}, {1'b0, m_er});
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_st(input logic [1:0] s, input int lim,
                         input string tag);
    int k;
    k = 0;
    while (st !== s && k < lim) begin
      step();
      k++;
    end
    chk(tag, st, s);
  endtask

  initial begin
    int dur;
    // power-up
    steps(5);
    chk("rst_core", {1'b0, core_n}, 2'd0);
    chk("rst_io", {1'b0, io_n}, 2'd0);
    chk("rst_state", st, 2'd0);
    chk("rst_flags", {glitch, early}, 2'd0);
    rst = 1'b0;
    steps(30);
    perst = 1'b1;
    steps(14);
    chk("pu_core_t14", {1'b0, core_n}, 2'd0);
    step();
    chk("pu_core_t15", {1'b0, core_n}, 2'd1);
    chk("pu_state_t15", st, 2'd2);
    steps(3);
    chk("pu_io_t18", {1'b0, io_n}, 2'd0);
    step();
    chk("pu_io_t19", {1'b0, io_n}, 2'd1);
    chk("pu_state_t19", st, 2'd3);

    // host reset from RUN, early re-release
    steps(3);
    perst = 1'b0;
    steps(2);
    chk("hr_core_t2", {1'b0, core_n}, 2'd1);
    step();
    chk("hr_core_t3", {1'b0, core_n}, 2'd0);
    chk("hr_io_t3", {1'b0, io_n}, 2'd0);
    chk("hr_state_t3", st, 2'd0);
    steps(2);
    perst = 1'b1;
    steps(7);
    chk("hr_early", {1'b0, early}, 2'd1);
    steps(15);
    chk("hr_core_t27", {1'b0, core_n}, 2'd0);
    step();
    chk("hr_core_t28", {1'b0, core_n}, 2'd1);
    wait_st(2'd3, 20, "hr_run");

    // short glitch while held in reset
    perst = 1'b0;
    steps(6);
    perst = 1'b1;
    steps(2);
    perst = 1'b0;
    steps(4);
    chk("gl_flag", {1'b0, glitch}, 2'd1);
    chk("gl_state", st, 2'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("gl_clr", {glitch, early}, 2'd0);

    // power-good drop during IO delay
    perst = 1'b1;
    wait_st(2'd2, 100, "pg_io_dly");
    pg = 1'b0;
    steps(2);
    chk("pg_core_t2", {1'b0, core_n}, 2'd1);
    step();
    chk("pg_core_t3", {1'b0, core_n}, 2'd0);
    chk("pg_io_t3", {1'b0, io_n}, 2'd0);
    chk("pg_state_t3", st, 2'd0);
    pg = 1'b1;
    wait_st(2'd3, 200, "pg_rerun");

    // assert path vs core-delay expiry in the same cycle
    perst = 1'b0;
    wait_st(2'd0, 10, "sim_reset");
    perst = 1'b1;
    wait_st(2'd1, 200, "sim_core_dly");
    steps(5);
    perst = 1'b0;
    steps(2);
    chk("sim_state_t7", st, 2'd1);
    step();
    chk("sim_state_t8", st, 2'd0);
    chk("sim_core_t8", {1'b0, core_n}, 2'd0);

    // synchronous reset from RUN
    perst = 1'b1;
    wait_st(2'd3, 200, "ir_run");
    rst = 1'b1;
    step();
    chk("ir_outs", {core_n, io_n}, 2'd0);
    chk("ir_state", st, 2'd0);
    chk("ir_flags", {glitch, early}, 2'd0);
    rst = 1'b0;

    // random segments
    for (int i = 0; i < 60; i++) begin
      perst = ($urandom_range(0, 3) != 0);
      pg    = ($urandom_range(0, 7) != 0);
      rst   = ($urandom_range(0, 29) == 0);
      clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) dur = $urandom_range(1, 5);
      else dur = $urandom_range(5, 40);
      step();
      rst = 1'b0;
      clr = 1'b0;
      steps(dur - 1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
